// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op/state encodings and op-class helpers for the HI/LO sequencer
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MADD  = 3'd4,
        OP_MADDU = 3'd5,
        OP_MSUB  = 3'd6,
        OP_MSUBU = 3'd7
    } md_op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_ACC  = 3'd2,
        S_DIV  = 3'd3,
        S_DONE = 3'd4
    } md_state_e;

    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

    function automatic logic is_signed(input md_op_e op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic logic is_acc(input md_op_e op);
        return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_sub(input md_op_e op);
        return (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_div(input md_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/div_iter.sv
// rtl/div_iter.sv - 32-bit unsigned restoring radix-2 divider core, one bit per step
module div_iter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quo_o,
    output logic [31:0] rem_o
);

    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_dvs;

    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_quo_nxt;
    logic [31:0] w_rem_nxt;

    // Partial remainder shifted by one dividend bit, then a trial subtract decides the quotient bit
    always_comb begin
        w_shift   = {r_rem, r_quo[31]};
        w_diff    = w_shift - {1'b0, r_dvs};
        w_ge      = ~w_diff[32];
        w_rem_nxt = w_ge ? w_diff[31:0] : w_shift[31:0];
        w_quo_nxt = {r_quo[30:0], w_ge};
    end

    // Outputs show the result of the step being taken this cycle so the caller
    // can capture the final quotient/remainder on the same edge as the last step
    assign quo_o = w_quo_nxt;
    assign rem_o = w_rem_nxt;

    // Load operands, or advance one restoring iteration
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_quo <= '0;
            r_rem <= '0;
            r_dvs <= '0;
        end else if (load_i) begin
            r_quo <= dividend_i;
            r_rem <= '0;
            r_dvs <= divisor_i;
        end else if (step_i) begin
            r_quo <= w_quo_nxt;
            r_rem <= w_rem_nxt;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - EX-stage sequencer for multi-cycle MULT/DIV/MADD/MSUB HI/LO ops
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  md_op_e      op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic        valid_o,
    output logic [1:0]  whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    md_state_e          r_state;
    logic [CNT_W-1:0]   r_cnt;
    md_op_e             r_op;
    logic [31:0]        r_hi_in;
    logic [31:0]        r_lo_in;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_valid;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [63:0]        r_pipe [MUL_CYCLES];

    logic               w_idle;
    logic               w_accept;
    logic               w_sgn;
    logic [63:0]        w_a64;
    logic [63:0]        w_b64;
    logic [63:0]        w_prod;
    logic               w_pipe_en;
    logic [63:0]        w_mul_res;
    logic [63:0]        w_acc_res;
    logic [31:0]        w_abs_a;
    logic [31:0]        w_abs_b;
    logic               w_div_load;
    logic               w_div_step;
    logic [31:0]        w_quo;
    logic [31:0]        w_rem;
    logic [31:0]        w_quo_fix;
    logic [31:0]        w_rem_fix;

    // Launch decode: the op is taken straight from the EX inputs in the start cycle
    always_comb begin
        w_idle   = (r_state == S_IDLE);
        w_accept = w_idle & start_i & ~flush_i;
        w_sgn    = is_signed(op_i);
        w_a64    = {{32{w_sgn & rs_i[31]}}, rs_i};
        w_b64    = {{32{w_sgn & rt_i[31]}}, rt_i};
        w_prod   = w_a64 * w_b64;
        w_abs_a  = (w_sgn & rs_i[31]) ? (32'd0 - rs_i) : rs_i;
        w_abs_b  = (w_sgn & rt_i[31]) ? (32'd0 - rt_i) : rt_i;
    end

    // The pipe only advances while a product is in flight, so its last stage
    // still holds this op's product during the S_ACC cycle
    assign w_pipe_en = w_accept | ((r_state == S_MUL) && (r_cnt != '0));
    assign w_mul_res = r_pipe[MUL_CYCLES-1];
    assign w_acc_res = is_sub(r_op) ? ({r_hi_in, r_lo_in} - w_mul_res)
                                    : ({r_hi_in, r_lo_in} + w_mul_res);

    // Multiplier register pipe fed by the combinational product of the launch operands
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < MUL_CYCLES; k++) r_pipe[k] <= '0;
        end else if (w_pipe_en) begin
            r_pipe[0] <= w_prod;
            for (int k = 1; k < MUL_CYCLES; k++) r_pipe[k] <= r_pipe[k-1];
        end
    end

    assign w_div_load = w_accept & is_div(op_i) & (rt_i != '0);
    assign w_div_step = (r_state == S_DIV);

    div_iter u_div_iter (
        .clk        (clk),
        .resetn     (resetn),
        .load_i     (w_div_load),
        .step_i     (w_div_step),
        .dividend_i (w_abs_a),
        .divisor_i  (w_abs_b),
        .quo_o      (w_quo),
        .rem_o      (w_rem)
    );

    // Signed fix-up: quotient negated on differing signs, remainder follows the dividend
    assign w_quo_fix = r_neg_q ? (32'd0 - w_quo) : w_quo;
    assign w_rem_fix = r_neg_r ? (32'd0 - w_rem) : w_rem;

    // Control FSM: flush wins over everything, results captured on entry to S_DONE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_MULT;
            r_hi_in <= '0;
            r_lo_in <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_valid <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_valid <= 1'b0;
            if (flush_i) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_i) begin
                            r_op    <= op_i;
                            r_hi_in <= hi_i;
                            r_lo_in <= lo_i;
                            r_neg_q <= w_sgn & (rs_i[31] ^ rt_i[31]);
                            r_neg_r <= w_sgn & rs_i[31];
                            if (is_div(op_i)) begin
                                if (rt_i == '0) begin
                                    r_hi    <= rs_i;
                                    r_lo    <= DIV0_QUOTIENT;
                                    r_valid <= 1'b1;
                                    r_state <= S_DONE;
                                end else begin
                                    r_cnt   <= CNT_W'(DIV_CYCLES - 1);
                                    r_state <= S_DIV;
                                end
                            end else begin
                                r_cnt   <= CNT_W'(MUL_CYCLES - 1);
                                r_state <= S_MUL;
                            end
                        end
                    end
                    S_MUL: begin
                        if (r_cnt == '0) begin
                            if (is_acc(r_op)) begin
                                r_state <= S_ACC;
                            end else begin
                                {r_hi, r_lo} <= w_mul_res;
                                r_valid      <= 1'b1;
                                r_state      <= S_DONE;
                            end
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    S_ACC: begin
                        {r_hi, r_lo} <= w_acc_res;
                        r_valid      <= 1'b1;
                        r_state      <= S_DONE;
                    end
                    S_DIV: begin
                        if (r_cnt == '0) begin
                            r_hi    <= w_rem_fix;
                            r_lo    <= w_quo_fix;
                            r_valid <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Pipeline hold and result pulse; a flush in S_DONE suppresses the writeback
    always_comb begin
        stall_o = w_accept | (r_state == S_MUL) | (r_state == S_ACC) | (r_state == S_DIV);
        busy_o  = ~w_idle;
        valid_o = r_valid & ~flush_i;
        whilo_o = {2{valid_o}};
    end

    assign hi_o = r_hi;
    assign lo_o = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - scoreboard bench for muldiv_ctrl against an arithmetic reference model
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int MULC = 2;
    localparam int DIVC = 32;

    logic        clk;
    logic        resetn;
    logic        start_i;
    md_op_e      op_i;
    logic [31:0] rs_i;
    logic [31:0] rt_i;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        flush_i;
    logic        stall_o;
    logic        busy_o;
    logic        valid_o;
    logic [1:0]  whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    muldiv_ctrl #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start_i (start_i),
        .op_i    (op_i),
        .rs_i    (rs_i),
        .rt_i    (rt_i),
        .hi_i    (hi_i),
        .lo_i    (lo_i),
        .flush_i (flush_i),
        .stall_o (stall_o),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .whilo_o (whilo_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation time limit reached, pending=%0d", sb_q.size());
        $fatal(1, "timeout");
    end

    // Reference: plain 64-bit arithmetic on sign/zero-extended operands
    function automatic logic [63:0] ref_res(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] h, input logic [31:0] l);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        logic [63:0] acc;
        logic [63:0] qv;
        logic [63:0] rv;
        bit          sg;
        sg  = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
        sa  = sg ? longint'($signed(a)) : longint'(a);
        sb  = sg ? longint'($signed(b)) : longint'(b);
        acc = {h, l};
        if (op == OP_DIV || op == OP_DIVU) begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q  = sa / sb;
            r  = sa % sb;
            qv = q;
            rv = r;
            return {rv[31:0], qv[31:0]};
        end
        p = sa * sb;
        case (op)
            OP_MADD, OP_MADDU: return acc + p;
            OP_MSUB, OP_MSUBU: return acc - p;
            default:           return p;
        endcase
    endfunction

    function automatic int ref_lat(input md_op_e op, input logic [31:0] b);
        if (op == OP_DIV || op == OP_DIVU) return (b == 32'd0) ? 1 : DIVC + 1;
        if (op == OP_MULT || op == OP_MULTU) return MULC + 1;
        return MULC + 2;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (resetn) begin
            if (valid_o) begin
                checks = checks + 1;
                if (sb_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL unexpected_valid: hi=%h lo=%h at cycle %0d", hi_o, lo_o, cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (hi_o !== e.hi || lo_o !== e.lo || cyc != e.due || whilo_o !== 2'b11) begin
                        errors = errors + 1;
                        $display("FAIL result: got hi=%h lo=%h whilo=%b cycle=%0d expected hi=%h lo=%h whilo=11 cycle=%0d",
                                 hi_o, lo_o, whilo_o, cyc, e.hi, e.lo, e.due);
                    end
                end
            end else begin
                checks = checks + 1;
                if (whilo_o !== 2'b00) begin
                    errors = errors + 1;
                    $display("FAIL whilo_idle: got %b expected 00 at cycle %0d", whilo_o, cyc);
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            start_i = 1'b0;
            flush_i = 1'b0;
        end
    endtask

    // Issue one op; flush_at<0 means no flush, otherwise flush in cycle T+flush_at.
    // Operands are scrambled after launch and a start is offered in the result cycle.
    task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] h, input logic [31:0] l, input int flush_at);
        int          lat;
        int          last;
        logic [63:0] res;
        exp_t        e;
        lat  = ref_lat(op, b);
        res  = ref_res(op, a, b, h, l);
        last = (flush_at >= 0) ? flush_at + 1 : lat;
        @(posedge clk);
        #1;
        start_i = 1'b1;
        op_i    = op;
        rs_i    = a;
        rt_i    = b;
        hi_i    = h;
        lo_i    = l;
        flush_i = (flush_at == 0);
        if (flush_at < 0) begin
            e.hi  = res[63:32];
            e.lo  = res[31:0];
            e.due = cyc + lat;
            sb_q.push_back(e);
        end
        for (int c = 0; c <= last; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
                start_i = (flush_at < 0) && (c == lat);
                op_i    = md_op_e'($urandom_range(0, 7));
                rs_i    = $urandom;
                rt_i    = $urandom;
                hi_i    = $urandom;
                lo_i    = $urandom;
                flush_i = (c == flush_at);
            end
            @(negedge clk);
            if (flush_at >= 0 && c == flush_at + 1) begin
                chk("busy_after_flush", {31'd0, busy_o}, 32'd0);
                chk("stall_after_flush", {31'd0, stall_o}, 32'd0);
            end else if (flush_at == 0 && c == 0) begin
                chk("stall_flush_start", {31'd0, stall_o}, 32'd0);
            end else if (c != flush_at) begin
                chk("stall", {31'd0, stall_o}, {31'd0, (c < lat)});
            end
        end
    endtask

    initial begin
        resetn  = 1'b0;
        start_i = 1'b0;
        op_i    = OP_MULT;
        rs_i    = '0;
        rt_i    = '0;
        hi_i    = '0;
        lo_i    = '0;
        flush_i = 1'b0;
        #23;
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_whilo", {30'd0, whilo_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_busy",  {31'd0, busy_o},  32'd0);
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_lo", lo_o, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        idle(2);

        // Multiply family, signed vs unsigned, back-to-back launches
        run_op(OP_MULT,  32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, -1);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, -1);
        // Divide corner cases
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, -1);
        run_op(OP_DIVU,  32'd100, 32'd7, 32'd0, 32'd0, -1);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, -1);
        // Accumulate with carry and borrow across the 32-bit boundary
        run_op(OP_MADD,  32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, -1);
        run_op(OP_MSUBU, 32'd1, 32'd1, 32'd0, 32'd0, -1);
        // Divide by zero
        run_op(OP_DIVU,  32'd5, 32'd0, 32'd0, 32'd0, -1);
        run_op(OP_DIV,   32'hFFFF_FFF0, 32'd0, 32'd0, 32'd0, -1);
        // Flush mid-divide, then an ordinary multiply
        run_op(OP_DIV,   32'd1000, 32'd3, 32'd0, 32'd0, 10);
        run_op(OP_MULT,  32'h0001_0000, 32'hFFFF_0000, 32'd0, 32'd0, -1);
        // Flush coinciding with start, flush in S_ACC, flush in the result cycle
        run_op(OP_MULTU, 32'd9, 32'd9, 32'd0, 32'd0, 0);
        run_op(OP_MSUB,  32'd3, 32'd4, 32'd5, 32'd6, MULC + 1);
        run_op(OP_MULT,  32'd3, 32'd4, 32'd0, 32'd0, MULC + 1);
        run_op(OP_MADDU, 32'hDEAD_BEEF, 32'h1234_5678, 32'h1111_1111, 32'h2222_2222, -1);

        // Asynchronous reset in the middle of a divide
        idle(1);
        start_i = 1'b1;
        op_i    = OP_DIVU;
        rs_i    = 32'd77;
        rt_i    = 32'd5;
        idle(9);
        #3;
        resetn = 1'b0;
        #1;
        chk("arst_valid", {31'd0, valid_o}, 32'd0);
        chk("arst_whilo", {30'd0, whilo_o}, 32'd0);
        chk("arst_stall", {31'd0, stall_o}, 32'd0);
        chk("arst_busy",  {31'd0, busy_o},  32'd0);
        chk("arst_hi", hi_o, 32'd0);
        chk("arst_lo", lo_o, 32'd0);
        #20;
        @(negedge clk);
        resetn = 1'b1;
        idle(1);
        chk("post_rst_busy", {31'd0, busy_o}, 32'd0);
        run_op(OP_DIVU, 32'd77, 32'd5, 32'd0, 32'd0, -1);

        // Randomized ops, some with biased corner operands
        for (int i = 0; i < 60; i++) begin
            run_op(md_op_e'($urandom_range(0, 7)), pick(), pick(), pick(), pick(), -1);
        end

        idle(40);
        chk("pending_results", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
